// File: rtl/mm_arbiter_pkg.sv
// Shared definitions for the two-requester main-memory arbiter.
// Contents:
//   state_t        - arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   DEF_*          - default values for the arbiter parameters
// Configuration macro used by the design: MM_ARB_FIXED_PRIO_EN
package mm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MM_LAT = 2;
  localparam int DEF_CNT_W  = 20;

endpackage

// File: rtl/mm_arbiter_pick.sv
// Winner selection between the instruction-cache (0) and data-cache (1)
// miss requests, plus the round-robin pointer.
// Ports:
//   clk, rst - clock and async active-high reset (round-robin build only)
//   take     - a grant is issued this edge; pointer follows the winner
//   req0/1   - pending requests
//   pick1    - 1 when requester 1 wins, 0 when requester 0 wins
// Macro MM_ARB_FIXED_PRIO_EN: requester 1 always wins ties and the
// pointer register (with its clock/reset/take ports) is not built.
module mm_arb_pick (
`ifndef MM_ARB_FIXED_PRIO_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic pick1
);

`ifdef MM_ARB_FIXED_PRIO_EN

  // Data-cache misses always win a tie.
  assign pick1 = req1;

`else

  // last1 records who was granted most recently. It resets to 1 so that
  // requester 0 wins the first tie.
  logic last1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last1 <= 1'b1;
    end else if (take) begin
      last1 <= pick1;
    end
  end

  // Requester 1 wins if it is alone, or if both are pending and
  // requester 0 was served last.
  assign pick1 = req1 && (!req0 || !last1);

`endif

endmodule

// File: rtl/mm_arbiter.sv
// Arbiter sharing one MainMemory read port between the instruction cache
// (requester 0) and the data cache (requester 1).
// Ports:
//   CLK, RESET          - clock, async active-high reset
//   REQ0/ADDR0          - instruction-cache miss request and address
//   REQ1/ADDR1          - data-cache miss request and address
//   Data_MM             - word returned by MainMemory
//   Access_MM, PC_MM    - memory strobe and latched address
//   GNT0/GNT1           - grant (one-hot or zero)
//   DONE0/DONE1         - one-cycle completion pulse
//   RDATA               - returned word, held outside RESP
//   BUSY                - high whenever the FSM is not IDLE
//   CNT_GNT0/CNT_GNT1   - saturating grant counters
// Macro MM_ARB_FIXED_PRIO_EN selects fixed priority (data cache first)
// instead of round-robin.
module mm_arbiter
  import mm_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MM_LAT = DEF_MM_LAT,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] Data_MM,
  output logic              Access_MM,
  output logic [ADDR_W-1:0] PC_MM,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic [CNT_W-1:0]  CNT_GNT0,
  output logic [CNT_W-1:0]  CNT_GNT1
);

  // The down-counter is loaded with MM_LAT-1 at the grant, so reaching
  // zero marks the last of the MM_LAT ACCESS cycles.
  localparam logic [3:0] LAT_LOAD = 4'(MM_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       take;
  logic       pick1;

  assign take = (state == IDLE) && (REQ0 || REQ1);

  mm_arb_pick u_pick (
`ifndef MM_ARB_FIXED_PRIO_EN
    .clk  (CLK),
    .rst  (RESET),
    .take (take),
`endif
    .req0 (REQ0),
    .req1 (REQ1),
    .pick1(pick1)
  );

  // Single FSM with all outputs registered. The winner's address is
  // copied into PC_MM at the grant so later ADDRx changes cannot leak
  // into the access. Reset abandons any access, so no DONE follows it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      Access_MM <= 1'b0;
      PC_MM     <= '0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      RDATA     <= '0;
      BUSY      <= 1'b0;
      CNT_GNT0  <= '0;
      CNT_GNT1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state     <= ACCESS;
            lat_cnt   <= LAT_LOAD;
            Access_MM <= 1'b1;
            BUSY      <= 1'b1;
            if (pick1) begin
              GNT1  <= 1'b1;
              PC_MM <= ADDR1;
              if (CNT_GNT1 != '1) CNT_GNT1 <= CNT_GNT1 + CNT_W'(1);
            end else begin
              GNT0  <= 1'b1;
              PC_MM <= ADDR0;
              if (CNT_GNT0 != '1) CNT_GNT0 <= CNT_GNT0 + CNT_W'(1);
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            state     <= RESP;
            Access_MM <= 1'b0;
            RDATA     <= Data_MM;
            DONE0     <= GNT0;
            DONE1     <= GNT1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          DONE0 <= 1'b0;
          DONE1 <= 1'b0;
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
